// File: rtl/step_counter.sv
// Bounded strided counter: up/down by step_i inside [lo_i, hi_i] with sync load and enable.
// Define STEP_CNT_SAT_EN to clamp at the bounds instead of wrapping to the opposite bound.
module step_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             cfg_err_o
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_cfg_err;

  // One extra bit so cnt+step and lo+step never alias modulo 2^WIDTH.
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH:0]   w_lo_plus_step;
  logic             w_up_fits;
  logic             w_dn_fits;
  logic             w_bad_cfg;
  logic [WIDTH-1:0] w_up_clamp;
  logic [WIDTH-1:0] w_dn_clamp;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_cfg_err_nxt;

  assign w_up_sum       = {1'b0, r_cnt} + {1'b0, step_i};
  assign w_lo_plus_step = {1'b0, lo_i} + {1'b0, step_i};
  assign w_up_fits      = (w_up_sum <= {1'b0, hi_i});
  assign w_dn_fits      = ({1'b0, r_cnt} >= w_lo_plus_step);
  assign w_bad_cfg      = (lo_i > hi_i);

`ifdef STEP_CNT_SAT_EN
  assign w_up_clamp = hi_i;
  assign w_dn_clamp = lo_i;
`else
  assign w_up_clamp = lo_i;
  assign w_dn_clamp = hi_i;
`endif

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_wrap_nxt    = 1'b0;
    w_cfg_err_nxt = r_cfg_err;
    if (load_i) begin
      w_cnt_nxt     = load_val_i;
      w_cfg_err_nxt = 1'b0;
    end else if (en_i) begin
      if (w_bad_cfg) begin
        w_cnt_nxt     = lo_i;
        w_cfg_err_nxt = 1'b1;
      end else begin
        w_cfg_err_nxt = 1'b0;
        if (!dir_i) begin
          if (w_up_fits) begin
            w_cnt_nxt = w_up_sum[WIDTH-1:0];
          end else begin
            w_cnt_nxt  = w_up_clamp;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          // Fits only when the result stays at or above lo_i.
          if (w_dn_fits) begin
            w_cnt_nxt = r_cnt - step_i;
          end else begin
            w_cnt_nxt  = w_dn_clamp;
            w_wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= RST_VAL;
      r_wrap    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_wrap    <= w_wrap_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign cnt_o     = r_cnt;
  assign wrap_o    = r_wrap;
  assign cfg_err_o = r_cfg_err;

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: walk, down-wrap, load priority, bad bounds, async reset.
// Expectations follow STEP_CNT_SAT_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_step_counter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             en_i;
  logic             dir_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] step_i;
  logic [WIDTH-1:0] lo_i;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] cnt_o;
  logic             wrap_o;
  logic             cfg_err_o;

  int n_pass  = 0;
  int n_total = 0;

  step_counter #(.WIDTH(WIDTH), .RST_VAL(8'd1)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .step_i     (step_i),
    .lo_i       (lo_i),
    .hi_i       (hi_i),
    .cnt_o      (cnt_o),
    .wrap_o     (wrap_o),
    .cfg_err_o  (cfg_err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
  endtask

  task automatic check3(input string tag, input int c, input int w, input int e);
    check({tag, ".cnt"},  32'(cnt_o),     32'(c));
    check({tag, ".wrap"}, 32'(wrap_o),    32'(w));
    check({tag, ".err"},  32'(cfg_err_o), 32'(e));
  endtask

  initial begin
    int e_cnt;
    int e_wrap;

    reset = 1'b1; en_i = 1'b0; dir_i = 1'b0; load_i = 1'b0; load_val_i = '0;
    step_i = 8'd2; lo_i = 8'd1; hi_i = 8'd255;
    tick(); tick();
    check3("reset", 1, 0, 0);

    // 1: default odd walk 1,3,...,255 then wrap to 1
    reset = 1'b0;
    en_i  = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      tick();
`ifdef STEP_CNT_SAT_EN
      e_cnt  = (k >= 127) ? 255 : 2 * k + 1;
      e_wrap = (k >= 128) ? 1 : 0;
`else
      e_cnt  = ((2 * k) % 256) + 1;
      e_wrap = (k == 128) ? 1 : 0;
`endif
      check({"walk.cnt.", $sformatf("%0d", k)},  32'(cnt_o),  32'(e_cnt));
      check({"walk.wrap.", $sformatf("%0d", k)}, 32'(wrap_o), 32'(e_wrap));
    end

    // 2: down by 3 in [10,40] from 16
    en_i = 1'b0; load_i = 1'b1; load_val_i = 8'd16;
    dir_i = 1'b1; step_i = 8'd3; lo_i = 8'd10; hi_i = 8'd40;
    tick();
    check3("down.load", 16, 0, 0);
    load_i = 1'b0; en_i = 1'b1;
    tick(); check3("down.13", 13, 0, 0);
    tick(); check3("down.10", 10, 0, 0);
`ifdef STEP_CNT_SAT_EN
    tick(); check3("down.clamp", 10, 1, 0);
    tick(); check3("down.park", 10, 1, 0);
`else
    tick(); check3("down.wrap40", 40, 1, 0);
    tick(); check3("down.37", 37, 0, 0);
`endif
    en_i = 1'b0;
    tick(); check3("hold", 32'(cnt_o) == 0 ? -1 : 32'(cnt_o), 0, 0);

    // 3: load wins over enable, no bounds check on load, out-of-range up step
    load_i = 1'b1; en_i = 1'b1; load_val_i = 8'd7;
    tick(); check3("load_en", 7, 0, 0);
    load_i = 1'b0; dir_i = 1'b0; step_i = 8'd5; lo_i = 8'd0; hi_i = 8'd9;
`ifdef STEP_CNT_SAT_EN
    tick(); check3("up.over", 9, 1, 0);
`else
    tick(); check3("up.over", 0, 1, 0);
`endif
    load_i = 1'b1; load_val_i = 8'd200;
    tick(); check3("load_oob", 200, 0, 0);
    load_i = 1'b0;
`ifdef STEP_CNT_SAT_EN
    tick(); check3("oob.up", 9, 1, 0);
`else
    tick(); check3("oob.up", 0, 1, 0);
`endif

    // 4: inverted bounds, then recovery
    lo_i = 8'd50; hi_i = 8'd20; step_i = 8'd2;
    tick(); check3("bad_cfg", 50, 0, 1);
    en_i = 1'b0;
    tick(); check3("bad_cfg.hold", 50, 0, 1);
    lo_i = 8'd5; en_i = 1'b1;
`ifdef STEP_CNT_SAT_EN
    tick(); check3("cfg_ok", 20, 1, 0);
    step_i = 8'd0;
    tick(); check3("step0", 20, 0, 0);
`else
    tick(); check3("cfg_ok", 5, 1, 0);
    step_i = 8'd0;
    tick(); check3("step0", 5, 0, 0);
`endif

    // 5: asynchronous reset mid-count at 99
    load_i = 1'b1; load_val_i = 8'd99; step_i = 8'd2; lo_i = 8'd1; hi_i = 8'd255;
    tick(); check3("at99", 99, 0, 0);
    load_i = 1'b0;
    #2 reset = 1'b1;
    #1 check3("areset.now", 1, 0, 0);
    tick(); check3("areset.held", 1, 0, 0);
    reset = 1'b0;
    tick(); check3("post_reset", 3, 0, 0);

    // 6: approach top bound from 253
    load_i = 1'b1; load_val_i = 8'd253;
    tick(); check3("top.load", 253, 0, 0);
    load_i = 1'b0;
    tick(); check3("top.255", 255, 0, 0);
`ifdef STEP_CNT_SAT_EN
    tick(); check3("top.sat1", 255, 1, 0);
    tick(); check3("top.sat2", 255, 1, 0);
`else
    tick(); check3("top.wrap", 1, 1, 0);
    tick(); check3("top.3", 3, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
